// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types for the serial adder.
//   state_t : FSM encoding (ST_IDLE, ST_RUN, ST_DONE), 2 bits.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_slice.sv
// adder_slice: combinational ripple of DIGIT full adders.
// Ports:
//   a, b   in  DIGIT  operand digits
//   c_in   in  1      carry into bit 0
//   s      out DIGIT  sum digit
//   c_out  out 1      carry out of bit DIGIT-1
module adder_slice #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             c_in,
  output logic [DIGIT-1:0] s,
  output logic             c_out
);

  always_comb begin
    logic w_cy;
    s    = '0;
    w_cy = c_in;
    for (int i = 0; i < DIGIT; i++) begin
      s[i] = a[i] ^ b[i] ^ w_cy;
      w_cy = (a[i] & b[i]) | (w_cy & (a[i] ^ b[i]));
    end
    c_out = w_cy;
  end

endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder, DIGIT bits per clock through one adder_slice,
// carry registered between cycles. start/busy/done handshake; result held until
// the next completion.
// Ports:
//   clock, reset  in   rising-edge clock, synchronous active-high reset
//   start         in   request, honoured only in IDLE or DONE
//   a, b, c_in    in   operands and carry-in, latched on accept
//   busy          out  high while running
//   done          out  one-cycle completion pulse
//   s, c_out      out  registered sum and carry out of bit WIDTH-1
// Build option SERIAL_ADDER_SUB_EN adds sub (in: a-b when high) and ovf (out: signed
// overflow, registered with s).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
`ifdef SERIAL_ADDER_SUB_EN
  output logic             c_out,
  output logic             ovf
`else
  output logic             c_out
`endif
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = $clog2(N) + 1;

  if ((WIDTH % DIGIT) != 0) begin : g_param_err
    $error("serial_adder: WIDTH must be a multiple of DIGIT");
  end

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_s;
  logic             r_carry, r_c_out;
  logic [CW-1:0]    r_cnt;
  logic             w_accept, w_last, w_cy;
  logic [DIGIT-1:0] w_sum;
  logic [WIDTH-1:0] w_acc_next, w_b_in;
  logic             w_c_in;
`ifdef SERIAL_ADDER_SUB_EN
  logic             r_a_msb, r_b_msb, r_ovf;

  // Subtract as a + ~b + 1; c_in is not used in that mode.
  assign w_b_in = sub ? ~b : b;
  assign w_c_in = sub ? 1'b1 : c_in;
  assign ovf    = r_ovf;
`else
  assign w_b_in = b;
  assign w_c_in = c_in;
`endif

  adder_slice #(
    .DIGIT(DIGIT)
  ) u_slice (
    .a    (r_a[DIGIT-1:0]),
    .b    (r_b[DIGIT-1:0]),
    .c_in (r_carry),
    .s    (w_sum),
    .c_out(w_cy)
  );

  // New digit enters at the top; after N steps the LSB digit has reached bit 0.
  assign w_acc_next = WIDTH'({w_sum, r_acc} >> DIGIT);

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_accept = start;
        if (start) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        w_last = (r_cnt == CW'(N - 1));
        if (w_last) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        w_accept     = start;
        w_state_next = start ? ST_RUN : ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_c_out <= 1'b0;
      r_cnt   <= '0;
`ifdef SERIAL_ADDER_SUB_EN
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= w_b_in;
        r_carry <= w_c_in;
        r_cnt   <= '0;
        r_acc   <= '0;
`ifdef SERIAL_ADDER_SUB_EN
        // Operand sign bits are shifted out during RUN; keep them for ovf.
        r_a_msb <= a[WIDTH-1];
        r_b_msb <= w_b_in[WIDTH-1];
`endif
      end else if (r_state == ST_RUN) begin
        r_a     <= r_a >> DIGIT;
        r_b     <= r_b >> DIGIT;
        r_carry <= w_cy;
        r_cnt   <= r_cnt + CW'(1);
        r_acc   <= w_acc_next;
        if (w_last) begin
          r_s     <= w_acc_next;
          r_c_out <= w_cy;
`ifdef SERIAL_ADDER_SUB_EN
          r_ovf   <= (r_a_msb == r_b_msb) && (w_acc_next[WIDTH-1] != r_a_msb);
`endif
        end
      end
    end
  end

  assign busy  = (r_state == ST_RUN);
  assign done  = (r_state == ST_DONE);
  assign s     = r_s;
  assign c_out = r_c_out;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: two instances (WIDTH 8 with DIGIT 1 and DIGIT 4) driven by directed
// steps; expected results are queued on issue and checked whenever done is seen.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic [1:0]   start, c_in, busy, done, c_out;
  logic [W-1:0] a [2];
  logic [W-1:0] b [2];
  logic [W-1:0] s [2];
`ifdef SERIAL_ADDER_SUB_EN
  logic [1:0]   sub, ovf;
`endif

  always #5 clock = ~clock;

  serial_adder #(.WIDTH(W), .DIGIT(1)) u_d1 (
    .clock(clock), .reset(reset), .start(start[0]), .a(a[0]), .b(b[0]), .c_in(c_in[0]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub[0]), .ovf(ovf[0]),
`endif
    .busy(busy[0]), .done(done[0]), .s(s[0]), .c_out(c_out[0])
  );

  serial_adder #(.WIDTH(W), .DIGIT(4)) u_d4 (
    .clock(clock), .reset(reset), .start(start[1]), .a(a[1]), .b(b[1]), .c_in(c_in[1]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub[1]), .ovf(ovf[1]),
`endif
    .busy(busy[1]), .done(done[1]), .s(s[1]), .c_out(c_out[1])
  );

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       v;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs == exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference arithmetic in plain integers.
  function automatic exp_t model(input logic [7:0] aa, input logic [7:0] bb, input logic ci,
                                 input logic sb);
    exp_t e;
    int   ua, ub, sa, sv, u, r;
    ua = int'(aa);
    ub = int'(bb);
    sa = int'($signed(aa));
    sv = int'($signed(bb));
    if (sb) begin
      u   = ua - ub;
      r   = sa - sv;
      e.c = (ua >= ub);
    end else begin
      u   = ua + ub + int'(ci);
      r   = sa + sv + int'(ci);
      e.c = (u > 255);
    end
    e.s = u[7:0];
    e.v = (r > 127) || (r < -128);
    return e;
  endfunction

  task automatic check_done(input int k);
    exp_t e;
    if (k == 0) begin
      if (q0.size() == 0) chk1("d1_unexpected_done", done[0], 1'b0);
      else begin
        e = q0.pop_front();
        chk8("d1_s", s[0], e.s);
        chk1("d1_c_out", c_out[0], e.c);
`ifdef SERIAL_ADDER_SUB_EN
        chk1("d1_ovf", ovf[0], e.v);
`endif
      end
    end else begin
      if (q1.size() == 0) chk1("d4_unexpected_done", done[1], 1'b0);
      else begin
        e = q1.pop_front();
        chk8("d4_s", s[1], e.s);
        chk1("d4_c_out", c_out[1], e.c);
`ifdef SERIAL_ADDER_SUB_EN
        chk1("d4_ovf", ovf[1], e.v);
`endif
      end
    end
  endtask

  // Advance one cycle; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    cyc++;
    if (done[0]) check_done(0);
    if (done[1]) check_done(1);
  endtask

  task automatic issue(input int k, input logic [7:0] aa, input logic [7:0] bb,
                       input logic ci, input logic sb, input bit push);
    start[k] = 1'b1;
    a[k]     = aa;
    b[k]     = bb;
    c_in[k]  = ci;
`ifdef SERIAL_ADDER_SUB_EN
    sub[k]   = sb;
`endif
    if (push) begin
      if (k == 0) q0.push_back(model(aa, bb, ci, sb));
      else        q1.push_back(model(aa, bb, ci, sb));
    end
  endtask

  task automatic wait_done(input int k, input int budget, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!done[k] && lat < budget);
    chk1("done_seen_within_budget", done[k], 1'b1);
  endtask

  // Full operation: accept, drop start, wait; lat is the done cycle relative to start.
  task automatic go(input int k, input logic [7:0] aa, input logic [7:0] bb, input logic ci,
                    input logic sb, output int lat);
    int l;
    issue(k, aa, bb, ci, sb, 1'b1);
    tick();
    start[k] = 1'b0;
    wait_done(k, 30, l);
    lat = l + 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lat, t1;
    reset = 1'b1;
    start = '0;
    c_in  = '0;
    a     = '{8'h00, 8'h00};
    b     = '{8'h00, 8'h00};
`ifdef SERIAL_ADDER_SUB_EN
    sub   = '0;
`endif
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      chk1("reset_busy", busy[k], 1'b0);
      chk1("reset_done", done[k], 1'b0);
      chk8("reset_s", s[k], 8'h00);
      chk1("reset_c_out", c_out[k], 1'b0);
    end
    reset = 1'b0;
    tick();

    // 1: D1 FF+01, busy in cycles 1..8, done exactly in cycle 9.
    issue(0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
    tick();
    start[0] = 1'b0;
    chk1("t1_busy_c1", busy[0], 1'b1);
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk1("t1_busy", busy[0], 1'b1);
      chk1("t1_no_early_done", done[0], 1'b0);
    end
    tick();
    chk1("t1_done_cycle9", done[0], 1'b1);
    chk1("t1_busy_low_in_done", busy[0], 1'b0);
    tick();
    chk1("t1_done_one_pulse", done[0], 1'b0);
    chk8("t1_s_held", s[0], 8'h00);
    chk1("t1_c_out_held", c_out[0], 1'b1);

    // 2: D4 3C+45+1, done in cycle 3; plus corner patterns.
    go(1, 8'h3C, 8'h45, 1'b1, 1'b0, lat);
    chki("t2_d4_latency", lat, 3);
    go(1, 8'hFF, 8'hFF, 1'b1, 1'b0, lat);
    chki("t2_d4_latency_b", lat, 3);
    go(1, 8'h00, 8'h00, 1'b0, 1'b0, lat);
    go(0, 8'h80, 8'h80, 1'b0, 1'b0, lat);
    chki("t2_d1_latency", lat, 9);

    // 3: start pulsed mid-RUN with zero operands is ignored.
    issue(0, 8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
    tick();
    start[0] = 1'b0;
    tick();
    tick();
    issue(0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    start[0] = 1'b0;
    wait_done(0, 30, lat);
    chki("t3_latency", lat + 4, 9);
    tick();
    tick();
    tick();
    chk1("t3_idle_busy", busy[0], 1'b0);
    chk8("t3_s_held", s[0], 8'h46);

    // 4: reset in RUN cycle 4 aborts without done; next op is fine.
    issue(0, 8'h0F, 8'h01, 1'b0, 1'b0, 1'b0);
    tick();
    start[0] = 1'b0;
    tick();
    tick();
    tick();
    chk1("t4_busy_c4", busy[0], 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk1("t4_busy_cleared", busy[0], 1'b0);
    chk1("t4_no_done", done[0], 1'b0);
    chk8("t4_s_cleared", s[0], 8'h00);
    chk1("t4_c_out_cleared", c_out[0], 1'b0);
    for (int i = 0; i < 10; i++) tick();
    chki("t4_queue_empty", q0.size(), 0);
    go(0, 8'hA5, 8'h5A, 1'b1, 1'b0, lat);
    chki("t4_latency_after_reset", lat, 9);

    // 5: start held through RUN and DONE; operand changes during RUN have no effect.
    issue(0, 8'h01, 8'h02, 1'b0, 1'b0, 1'b1);
    tick();
    a[0]    = 8'h10;
    b[0]    = 8'h20;
    c_in[0] = 1'b1;
    q0.push_back(model(8'h10, 8'h20, 1'b1, 1'b0));
    wait_done(0, 30, lat);
    chki("t5_first_latency", lat + 1, 9);
    t1 = cyc;
    tick();
    start[0] = 1'b0;
    chk1("t5_rerun_busy", busy[0], 1'b1);
    wait_done(0, 30, lat);
    chki("t5_done_spacing", cyc - t1, 9);
    chki("t5_queue_drained", q0.size(), 0);

`ifdef SERIAL_ADDER_SUB_EN
    // 6: subtraction with borrow and signed overflow.
    go(0, 8'h05, 8'h07, 1'b0, 1'b1, lat);
    go(0, 8'h80, 8'h01, 1'b1, 1'b1, lat);
    go(1, 8'h05, 8'h07, 1'b0, 1'b1, lat);
    go(1, 8'h80, 8'h01, 1'b0, 1'b1, lat);
    chki("t6_d4_latency", lat, 3);
`endif

    tick();
    tick();
    chki("final_queue_d1", q0.size(), 0);
    chki("final_queue_d4", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
